sram_axi_slave: RTL and testbench

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

---
 rtl/axi_pkg.sv | 26 ++
 rtl/sram_axi_slave.sv | 181 ++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared widths, AXI encodings and FSM state type for the SRAM AXI slave
package axi_pkg;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 4;
    localparam int AXI_STRB_W = 4;
    localparam int SRAM_AW_W  = 14;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RFETCH = 3'd1,
        ST_RDATA  = 3'd2,
        ST_WDATA  = 3'd3,
        ST_WRESP  = 3'd4
    } state_e;

endpackage

// File: rtl/sram_axi_slave.sv
// rtl/sram_axi_slave.sv - single-outstanding AXI slave in front of a synchronous word SRAM
module sram_axi_slave
    import axi_pkg::*;
#(
    parameter int ID_W    = AXI_ID_W,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int LEN_W   = AXI_LEN_W,
    parameter int SRAM_AW = SRAM_AW_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,

    input  logic [DATA_W-1:0]     WDATA,
    input  logic [AXI_STRB_W-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,

    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,

    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,

    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,

    output logic                  CS,
    output logic                  OE,
    output logic [AXI_STRB_W-1:0] WEB,
    output logic [SRAM_AW-1:0]    A,
    output logic [DATA_W-1:0]     DI,
    input  logic [DATA_W-1:0]     DO
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [1:0]         burst_q, burst_d;
    logic               err_q, err_d;

    logic               last_beat;
    logic               w_fire;
    logic [SRAM_AW-1:0] addr_next;

    // Size is fixed at one word and the byte offset / high address bits are not decoded.
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE, ARSIZE,
                             AWADDR[1:0], AWADDR[ADDR_W-1:SRAM_AW+2],
                             ARADDR[1:0], ARADDR[ADDR_W-1:SRAM_AW+2]};

    assign last_beat = (beat_q == len_q);
    assign w_fire    = (state_q == ST_WDATA) && WVALID;
    // FIXED bursts hit the same word; INCR and WRAP both just step and wrap at the SRAM size.
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + SRAM_AW'(1);

    // Transaction sequencing: address capture, beat counting and burst termination.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[SRAM_AW+1:2];
                    len_d   = AWLEN;
                    burst_d = AWBURST;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_WDATA;
                end else if (ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[SRAM_AW+1:2];
                    len_d   = ARLEN;
                    burst_d = ARBURST;
                    beat_d  = '0;
                    state_d = ST_RFETCH;
                end
            end
            ST_RFETCH: state_d = ST_RDATA;
            ST_RDATA: begin
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        addr_d  = addr_next;
                        state_d = ST_RFETCH;
                    end
                end
            end
            ST_WDATA: begin
                if (WVALID) begin
                    if (WLAST != last_beat) begin
                        err_d = 1'b1;
                    end
                    addr_d = addr_next;
                    beat_d = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // Channel handshakes and SRAM strobes decoded from the current state.
    always_comb begin
        AWREADY = (state_q == ST_IDLE);
        ARREADY = (state_q == ST_IDLE) && !AWVALID;
        WREADY  = (state_q == ST_WDATA);
        RVALID  = (state_q == ST_RDATA);
        RID     = id_q;
        RDATA   = DO;
        RRESP   = RESP_OKAY;
        RLAST   = (state_q == ST_RDATA) && last_beat;
        BVALID  = (state_q == ST_WRESP);
        BID     = id_q;
        BRESP   = err_q ? RESP_SLVERR : RESP_OKAY;
        OE      = (state_q == ST_RFETCH) || (state_q == ST_RDATA);
        CS      = OE || w_fire;
        WEB     = w_fire ? ~WSTRB : {AXI_STRB_W{1'b1}};
        A       = addr_q;
        DI      = WDATA;
    end

endmodule

// File: tb/tb_sram_axi_slave.sv
// tb/tb_sram_axi_slave.sv - scoreboard bench for sram_axi_slave with a word-memory reference
module tb_sram_axi_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, DI, DO;
    logic [3:0]  AWLEN, ARLEN, WSTRB, WEB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CS, OE;
    logic [13:0] A;

    always #5 clk = ~clk;

    sram_axi_slave dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    // Synchronous SRAM: read data appears the cycle after a sampled OE access.
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    always @(posedge clk) begin
        if (CS && OE) DO <= mem[A];
        if (CS)
            for (int b = 0; b < 4; b++)
                if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
    end

    typedef struct packed { logic [7:0] id; logic [31:0] data; logic last; logic [13:0] addr; } r_exp_t;
    typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [13:0] addr; logic [3:0] web; logic [31:0] data; } w_exp_t;
    r_exp_t r_q[$];
    b_exp_t b_q[$];
    w_exp_t w_q[$];
    r_exp_t r_e;
    b_exp_t b_e;
    w_exp_t w_e;

    int n_checks = 0;
    int n_err    = 0;
    bit busy     = 1'b0;

    logic [31:0] wd_a [16];
    logic [3:0]  ws_a [16];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // R channel monitor.
    always @(negedge clk) begin
        if (rst && RVALID && RREADY) begin
            if (r_q.size() == 0) chk(1'b0, "r_unexpected", {32'd0, RDATA}, 64'd0);
            else begin
                r_e = r_q.pop_front();
                chk(RID == r_e.id, "rid", {56'd0, RID}, {56'd0, r_e.id});
                chk(RDATA == r_e.data, "rdata", {32'd0, RDATA}, {32'd0, r_e.data});
                chk(RLAST == r_e.last, "rlast", {63'd0, RLAST}, {63'd0, r_e.last});
                chk(RRESP == RESP_OKAY, "rresp", {62'd0, RRESP}, 64'd0);
                chk(A == r_e.addr, "raddr", {50'd0, A}, {50'd0, r_e.addr});
            end
        end
    end

    // B channel monitor.
    always @(negedge clk) begin
        if (rst && BVALID && BREADY) begin
            if (b_q.size() == 0) chk(1'b0, "b_unexpected", {62'd0, BRESP}, 64'd0);
            else begin
                b_e = b_q.pop_front();
                chk(BID == b_e.id, "bid", {56'd0, BID}, {56'd0, b_e.id});
                chk(BRESP == b_e.resp, "bresp", {62'd0, BRESP}, {62'd0, b_e.resp});
            end
        end
    end

    // SRAM write port monitor and single-outstanding invariant.
    always @(negedge clk) begin
        if (rst) begin
            if (CS && WEB != 4'hf) begin
                if (w_q.size() == 0) chk(1'b0, "sram_write_unexpected", {46'd0, A, WEB}, 64'd0);
                else begin
                    w_e = w_q.pop_front();
                    chk(A == w_e.addr, "waddr", {50'd0, A}, {50'd0, w_e.addr});
                    chk(WEB == w_e.web, "web", {60'd0, WEB}, {60'd0, w_e.web});
                    chk(DI == w_e.data, "di", {32'd0, DI}, {32'd0, w_e.data});
                    chk(!OE, "oe_during_write", {63'd0, OE}, 64'd0);
                end
            end
            chk(!(ARREADY && (AWVALID || busy)), "arready_excl", {63'd0, ARREADY}, 64'd0);
            chk(!(AWREADY && busy), "awready_busy", {63'd0, AWREADY}, 64'd0);
        end
    end

    // All tasks start and return one time unit after a rising edge.
    task automatic ar_handshake(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!ARREADY && n < 200);
        if (!ARREADY) chk(1'b0, "ar_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        busy = 1'b1;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!RVALID && n < 100);
    endtask

    task automatic push_read(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst, input int nbeats);
        logic [13:0] a = addr[15:2];
        for (int i = 0; i < nbeats; i++) begin
            r_q.push_back('{id: id, data: ref_mem[a], last: (i == len), addr: a});
            if (burst != BURST_FIXED) a = a + 14'd1;
        end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n);
        int n;
        logic [31:0] held;
        push_read(id, addr, int'(len), burst, int'(len) + 1);
        ar_handshake(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            RREADY = (i == stall_beat) ? 1'b0 : 1'b1;
            wait_rvalid(n);
            if (!RVALID) begin
                chk(1'b0, "rvalid_timeout", 64'd0, 64'd1);
                r_q.delete();
                @(posedge clk); #1;
                break;
            end
            chk(n == 2, "r_latency", n, 64'd2);
            if (i == stall_beat) begin
                held = RDATA;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk(RVALID && RDATA == held, "r_stall_stable", {32'd0, RDATA}, {32'd0, held});
                end
                RREADY = 1'b1;
            end
            @(posedge clk); #1;
        end
        RREADY = 1'b0;
        busy = 1'b0;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i <= len; i++) begin
            wd_a[i] = $urandom;
            ws_a[i] = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int err_beat, input int bdelay);
        logic [13:0] a = addr[15:2];
        bit err = 1'b0;
        logic wl [16];
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            w_q.push_back('{addr: a, web: ~ws_a[i], data: wd_a[i]});
            for (int b = 0; b < 4; b++)
                if (ws_a[i][b]) ref_mem[a][8*b +: 8] = wd_a[i][8*b +: 8];
            wl[i] = (i == int'(len)) ^ (i == err_beat);
            if (wl[i] != (i == int'(len))) err = 1'b1;
            if (burst != BURST_FIXED) a = a + 14'd1;
        end
        b_q.push_back('{id: id, resp: err ? RESP_SLVERR : RESP_OKAY});
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!AWREADY && n < 200);
        if (!AWREADY) chk(1'b0, "aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        busy = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                @(posedge clk); #1;
            end
            WDATA = wd_a[i]; WSTRB = ws_a[i]; WLAST = wl[i]; WVALID = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!WREADY && n < 100);
            if (!WREADY) chk(1'b0, "wready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
        repeat (bdelay) begin @(posedge clk); #1; end
        BREADY = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!BVALID && n < 100);
        if (!BVALID) chk(1'b0, "bvalid_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        BREADY = 1'b0;
        busy = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [3:0]  len;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        #2;
        chk(CS == 1'b0 && OE == 1'b0, "reset_cs_oe", {62'd0, CS, OE}, 64'd0);
        chk(WEB == 4'hf, "reset_web", {60'd0, WEB}, 64'hf);
        chk(!RVALID && !BVALID && !WREADY, "reset_valids", {61'd0, RVALID, BVALID, WREADY}, 64'd0);
        chk(AWREADY && ARREADY, "reset_idle_ready", {62'd0, AWREADY, ARREADY}, 64'd3);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single-beat read of a preloaded word.
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        do_read(8'h21, 32'h0000_0010, 4'd0, BURST_INCR, -1, 0);

        // Four-beat INCR read wrapping the SRAM top, stalled on the first beat.
        for (int i = 0; i < 4; i++) begin
            mem[(16382 + i) % 16384] = 32'hA5A5_0000 + i;
            ref_mem[(16382 + i) % 16384] = 32'hA5A5_0000 + i;
        end
        do_read(8'h35, 32'h0000_FFF8, 4'd3, BURST_INCR, 0, 3);

        // Byte-strobed single write, then read back.
        wd_a[0] = 32'h1122_3344;
        ws_a[0] = 4'b0101;
        do_write(8'h4C, 32'h0000_0020, 4'd0, BURST_INCR, -1, 1);
        do_read(8'h4D, 32'h0000_0020, 4'd0, BURST_INCR, -1, 0);

        // AW and AR raised together: the write goes first, the read follows.
        ARID = 8'h77; ARADDR = 32'h0000_0020; ARLEN = 4'd0; ARBURST = BURST_INCR; ARVALID = 1'b1;
        fill_random(0);
        do_write(8'h66, 32'h0000_0020, 4'd0, BURST_INCR, -1, 2);
        do_read(8'h77, 32'h0000_0020, 4'd0, BURST_INCR, -1, 0);

        // Early WLAST on a two-beat burst still writes both beats but flags an error.
        fill_random(1);
        do_write(8'h12, 32'h0000_0100, 4'd1, BURST_INCR, 0, 0);
        do_read(8'h13, 32'h0000_0100, 4'd1, BURST_INCR, -1, 0);

        // Reset while the second beat of a four-beat read is on the bus.
        push_read(8'h90, 32'h0000_0100, 3, BURST_INCR, 1);
        ar_handshake(8'h90, 32'h0000_0100, 4'd3, BURST_INCR);
        RREADY = 1'b1;
        wait_rvalid(n);
        @(posedge clk); #1;
        RREADY = 1'b0;
        wait_rvalid(n);
        chk(RVALID, "rvalid_before_reset", {63'd0, RVALID}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk(!RVALID && !CS && !OE, "reset_midburst_outputs", {61'd0, RVALID, CS, OE}, 64'd0);
        r_q.delete();
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk(AWREADY && ARREADY && !RVALID, "idle_after_reset", {61'd0, AWREADY, ARREADY, RVALID}, 64'd6);
        @(posedge clk); #1;
        do_read(8'h91, 32'h0000_0104, 4'd2, BURST_INCR, -1, 0);

        // Randomized mixed traffic.
        for (int t = 0; t < 40; t++) begin
            addr  = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 255)) << 2)
                                                : (32'h0000_FF00 + (32'($urandom_range(0, 63)) << 2));
            addr  = addr | ($urandom & 32'hFFFF_0000);
            burst = 2'($urandom_range(0, 2));
            len   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                fill_random(int'(len));
                do_write(8'($urandom), addr, len, burst,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
                         $urandom_range(0, 3));
            end else begin
                do_read(8'($urandom), addr, len, burst,
                        ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(len)) : -1,
                        $urandom_range(1, 4));
            end
        end

        repeat (3) @(posedge clk);
        chk(r_q.size() == 0, "r_queue_drained", r_q.size(), 64'd0);
        chk(b_q.size() == 0, "b_queue_drained", b_q.size(), 64'd0);
        chk(w_q.size() == 0, "w_queue_drained", w_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
